// File: rtl/draw_number_field.sv
`default_nettype none
// ============================================================================
//  Module   : draw_number_field
//  Purpose  : Renders N_ITEMS snapshotted unsigned values as right-aligned
//             decimal fields. Each value is converted to BCD by sequential
//             double-dabble, optionally blanked above its most significant
//             digit, saturated to all-nines when out of range, and drawn one
//             glyph pixel at a time through a plot/plot_ready handshake.
//  Revision : 1.0  initial release
// ============================================================================
module draw_number_field #(
    parameter int N_ITEMS     = 5,
    parameter int NUM_DIGITS  = 5,
    parameter int VALUE_W     = 15,
    parameter int DIGIT_W     = 6,
    parameter int DIGIT_H     = 9,
    parameter int COLOUR_W    = 9,
    parameter int ADDR_W      = 10,
    parameter int BLANK_ZEROS = 1,
    parameter int BG_COLOUR   = 0
) (
    input  logic                         clock,
    input  logic                         resetn,
    input  logic                         go,
    input  logic [N_ITEMS*VALUE_W-1:0]   values,
    input  logic [N_ITEMS*9-1:0]         item_x,
    input  logic [N_ITEMS*9-1:0]         item_y,
    output logic [ADDR_W-1:0]            rom_addr,
    input  logic [COLOUR_W-1:0]          rom_q,
    output logic [8:0]                   x,
    output logic [8:0]                   y,
    output logic [COLOUR_W-1:0]          colour,
    output logic                         plot,
    input  logic                         plot_ready,
    output logic                         busy,
    output logic                         done
);

    // BCD digits needed to hold any VALUE_W-bit value: ceil(VALUE_W*0.302 + 1)
    localparam int BCD_DIGITS = (VALUE_W * 302 + 1999) / 1000;
    localparam int TOT_DIGITS = (BCD_DIGITS > NUM_DIGITS) ? BCD_DIGITS : NUM_DIGITS;
    localparam int BCD_W      = 4 * TOT_DIGITS;
    localparam int IT_W       = (N_ITEMS    > 1) ? $clog2(N_ITEMS)    : 1;
    localparam int DG_W       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int DX_W       = (DIGIT_W    > 1) ? $clog2(DIGIT_W)    : 1;
    localparam int DY_W       = (DIGIT_H    > 1) ? $clog2(DIGIT_H)    : 1;
    localparam int BC_W       = (VALUE_W    > 1) ? $clog2(VALUE_W)    : 1;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_LOAD_ITEM = 4'd1,
        S_CONVERT   = 4'd2,
        S_SAT       = 4'd3,
        S_DIG_SETUP = 4'd4,
        S_PIX_ADDR  = 4'd5,
        S_PIX_PLOT  = 4'd6,
        S_NEXT_DIG  = 4'd7,
        S_NEXT_ITEM = 4'd8,
        S_DONE      = 4'd9
    } state_t;

    state_t                 state;
    state_t                 state_next;

    logic [VALUE_W-1:0]     snap [N_ITEMS];
    logic [VALUE_W-1:0]     shift;
    logic [BCD_W-1:0]       bcd;
    logic [BCD_W-1:0]       bcd_adj;
    logic [BCD_W-1:0]       bcd_fixed;
    logic [BC_W-1:0]        bit_cnt;
    logic [IT_W-1:0]        item;
    logic [DG_W-1:0]        digit;
    logic [DG_W-1:0]        msd;
    logic [DG_W-1:0]        msd_calc;
    logic [DX_W-1:0]        dx;
    logic [DY_W-1:0]        dy;

    logic                   sat;
    logic [VALUE_W-1:0]     snap_sel;
    logic [8:0]             base_x;
    logic [8:0]             base_y;
    logic [3:0]             cur_digit;
    logic                   blank;
    logic                   bit_last;
    logic                   dx_last;
    logic                   dy_last;
    logic                   digit_last;
    logic                   item_last;

    assign bit_last   = (bit_cnt == BC_W'(VALUE_W - 1));
    assign dx_last    = (dx      == DX_W'(DIGIT_W - 1));
    assign dy_last    = (dy      == DY_W'(DIGIT_H - 1));
    assign digit_last = (digit   == DG_W'(NUM_DIGITS - 1));
    assign item_last  = (item    == IT_W'(N_ITEMS - 1));

    // Out of range when any BCD nibble above the displayed field is nonzero
    generate
        if (TOT_DIGITS > NUM_DIGITS) begin : g_sat_hi
            assign sat = |bcd[BCD_W-1:4*NUM_DIGITS];
        end else begin : g_sat_none
            assign sat = 1'b0;
        end
    endgenerate

    // State register
    always_ff @(posedge clock) begin
        if (!resetn) state <= S_IDLE;
        else         state <= state_next;
    end

    // Next-state logic and handshake outputs
    always_comb begin
        state_next = state;
        plot       = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            S_IDLE:      if (go) state_next = S_LOAD_ITEM;
            S_LOAD_ITEM: begin busy = 1'b1; state_next = S_CONVERT; end
            S_CONVERT:   begin busy = 1'b1; if (bit_last) state_next = S_SAT; end
            S_SAT:       begin busy = 1'b1; state_next = S_DIG_SETUP; end
            S_DIG_SETUP: begin busy = 1'b1; state_next = S_PIX_ADDR; end
            S_PIX_ADDR:  begin busy = 1'b1; state_next = S_PIX_PLOT; end
            S_PIX_PLOT: begin
                busy = 1'b1;
                plot = 1'b1;
                if (plot_ready) state_next = (dx_last && dy_last) ? S_NEXT_DIG : S_PIX_ADDR;
            end
            S_NEXT_DIG:  begin busy = 1'b1; state_next = digit_last ? S_NEXT_ITEM : S_DIG_SETUP; end
            S_NEXT_ITEM: begin busy = 1'b1; state_next = item_last ? S_DONE : S_LOAD_ITEM; end
            S_DONE:      begin done = 1'b1; state_next = S_IDLE; end
            default:     state_next = S_IDLE;
        endcase
    end

    // Per-item operand and screen position selected by the item counter
    always_comb begin
        snap_sel = '0;
        base_x   = '0;
        base_y   = '0;
        for (int i = 0; i < N_ITEMS; i++) begin
            if (int'(item) == i) begin
                snap_sel = snap[i];
                base_x   = item_x[i*9 +: 9];
                base_y   = item_y[i*9 +: 9];
            end
        end
    end

    // Double-dabble correction: add 3 to every nibble that is 5 or more
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < TOT_DIGITS; i++) begin
            if (bcd[i*4 +: 4] >= 4'd5) bcd_adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
        end
    end

    // Saturated digits and the index of the highest nonzero digit
    always_comb begin
        bcd_fixed = bcd;
        msd_calc  = '0;
        if (sat) begin
            for (int i = 0; i < NUM_DIGITS; i++) bcd_fixed[i*4 +: 4] = 4'd9;
        end
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (bcd_fixed[i*4 +: 4] != 4'd0) msd_calc = DG_W'(i);
        end
    end

    // Current glyph index
    always_comb begin
        cur_digit = 4'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (int'(digit) == i) cur_digit = bcd[i*4 +: 4];
        end
    end

    // Glyph ROM address and pixel outputs; x/y wrap modulo 512
    always_comb begin
        rom_addr = ADDR_W'(int'(dy) * (10 * DIGIT_W) + int'(cur_digit) * DIGIT_W + int'(dx));
        blank    = (BLANK_ZEROS != 0) && (digit > msd);
        x        = '0;
        y        = '0;
        colour   = '0;
        if (state == S_PIX_PLOT) begin
            x      = 9'(int'(base_x) - int'(digit) * DIGIT_W + int'(dx));
            y      = 9'(int'(base_y) + int'(dy));
            colour = blank ? COLOUR_W'(BG_COLOUR) : rom_q;
        end
    end

    // Snapshot all values when a draw is accepted
    always_ff @(posedge clock) begin
        if (!resetn) begin
            for (int i = 0; i < N_ITEMS; i++) snap[i] <= '0;
        end else if (state == S_IDLE && go) begin
            for (int i = 0; i < N_ITEMS; i++) snap[i] <= values[i*VALUE_W +: VALUE_W];
        end
    end

    // Conversion datapath and drawing counters
    always_ff @(posedge clock) begin
        if (!resetn) begin
            shift   <= '0;
            bcd     <= '0;
            bit_cnt <= '0;
            item    <= '0;
            digit   <= '0;
            msd     <= '0;
            dx      <= '0;
            dy      <= '0;
        end else begin
            case (state)
                S_IDLE: if (go) item <= '0;
                S_LOAD_ITEM: begin
                    shift   <= snap_sel;
                    bcd     <= '0;
                    bit_cnt <= '0;
                end
                S_CONVERT: begin
                    bcd     <= {bcd_adj[BCD_W-2:0], shift[VALUE_W-1]};
                    shift   <= shift << 1;
                    bit_cnt <= bit_cnt + BC_W'(1);
                end
                S_SAT: begin
                    bcd   <= bcd_fixed;
                    msd   <= msd_calc;
                    digit <= '0;
                end
                S_DIG_SETUP: begin
                    dx <= '0;
                    dy <= '0;
                end
                S_PIX_PLOT: begin
                    if (plot_ready) begin
                        if (!dx_last) begin
                            dx <= dx + DX_W'(1);
                        end else begin
                            dx <= '0;
                            if (!dy_last) dy <= dy + DY_W'(1);
                        end
                    end
                end
                S_NEXT_DIG:  if (!digit_last) digit <= digit + DG_W'(1);
                S_NEXT_ITEM: if (!item_last) item <= item + IT_W'(1);
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_draw_number_field.sv
`default_nettype none
// ============================================================================
//  Module   : tb_draw_number_field
//  Purpose  : Self-checking bench for draw_number_field: randomized values
//             compared pixel-by-pixel against a decimal-arithmetic model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_draw_number_field;

    localparam int N  = 5;
    localparam int ND = 5;
    localparam int VW = 15;
    localparam int W  = 6;
    localparam int H  = 9;
    localparam int CW = 9;
    localparam int AW = 10;
    localparam int PER_ITEM  = 2 + VW + ND * (2 + 2 * W * H) + 1;
    localparam int DONE_CYC  = N * PER_ITEM;
    localparam int PER_ITEM3 = 2 + VW + 3 * (2 + 2 * W * H) + 1;

    typedef struct { int x; int y; int c; int a; } pix_t;

    logic              clock = 1'b0;
    logic              resetn = 1'b0;
    logic              go = 1'b0;
    logic [N*VW-1:0]   values = '0;
    logic [N*9-1:0]    item_x = '0;
    logic [N*9-1:0]    item_y = '0;
    logic [AW-1:0]     rom_addr;
    logic [CW-1:0]     rom_q = '0;
    logic [8:0]        x, y;
    logic [CW-1:0]     colour;
    logic              plot;
    logic              plot_ready = 1'b1;
    logic              busy, done;

    logic              go3 = 1'b0;
    logic [2*VW-1:0]   values3 = '0;
    logic [2*9-1:0]    item_x3 = '0;
    logic [2*9-1:0]    item_y3 = '0;
    logic [AW-1:0]     rom_addr3;
    logic [CW-1:0]     rom_q3 = '0;
    logic [8:0]        x3, y3;
    logic [CW-1:0]     colour3;
    logic              plot3;
    logic              ready3 = 1'b1;
    logic              busy3, done3;

    int n_tests = 0;
    int n_fail  = 0;

    pix_t cap_q[$];
    pix_t exp_q[$];
    int cur_vals[8];
    int cur_x[8];
    int cur_y[8];
    logic [N*VW-1:0] mid_values;

    int done_cnt, done_cyc, stall_cycles;
    bit busy_at_done, busy_pre_done, busy_first, timed_out, stall_changed;
    bit post_busy, post_plot, aborted, busy_pre_abort, abort_plot, abort_busy, abort_done;

    draw_number_field dut (
        .clock(clock), .resetn(resetn), .go(go), .values(values),
        .item_x(item_x), .item_y(item_y), .rom_addr(rom_addr), .rom_q(rom_q),
        .x(x), .y(y), .colour(colour), .plot(plot), .plot_ready(plot_ready),
        .busy(busy), .done(done)
    );

    draw_number_field #(.N_ITEMS(2), .NUM_DIGITS(3)) dut3 (
        .clock(clock), .resetn(resetn), .go(go3), .values(values3),
        .item_x(item_x3), .item_y(item_y3), .rom_addr(rom_addr3), .rom_q(rom_q3),
        .x(x3), .y(y3), .colour(colour3), .plot(plot3), .plot_ready(ready3),
        .busy(busy3), .done(done3)
    );

    always #5 clock = ~clock;

    function automatic int rom_fn(input int a);
        return (a * 5 + 1) % 512;
    endfunction

    // Synchronous glyph ROM models
    always @(posedge clock) begin
        rom_q  <= CW'(rom_fn(int'(rom_addr)));
        rom_q3 <= CW'(rom_fn(int'(rom_addr3)));
    end

    // Expected pixel stream from decimal arithmetic on the values
    function automatic void build_exp(input int vals[8], input int xs[8], input int ys[8],
                                      input int n_items, input int nd);
        exp_q.delete();
        for (int it = 0; it < n_items; it++) begin
            int dig[8];
            int lim = 1;
            int tmp = vals[it];
            int msd = 0;
            for (int d = 0; d < nd; d++) lim = lim * 10;
            for (int d = 0; d < nd; d++) begin
                dig[d] = (vals[it] >= lim) ? 9 : tmp % 10;
                tmp = tmp / 10;
            end
            for (int d = 0; d < nd; d++) if (dig[d] != 0) msd = d;
            for (int d = 0; d < nd; d++)
                for (int r = 0; r < H; r++)
                    for (int c = 0; c < W; c++) begin
                        pix_t p;
                        p.a = r * 10 * W + dig[d] * W + c;
                        p.x = (((xs[it] - d * W + c) % 512) + 512) % 512;
                        p.y = (ys[it] + r) % 512;
                        p.c = (d > msd) ? 0 : rom_fn(p.a);
                        exp_q.push_back(p);
                    end
        end
    endfunction

    function automatic int count_mism(output int first);
        int m = 0;
        first = -1;
        for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++) begin
            if (cap_q[i].x != exp_q[i].x || cap_q[i].y != exp_q[i].y ||
                cap_q[i].c != exp_q[i].c || cap_q[i].a != exp_q[i].a) begin
                if (first < 0) first = i;
                m++;
            end
        end
        return m;
    endfunction

    task automatic set_bus();
        for (int i = 0; i < N; i++) begin
            values[i*VW +: VW] = VW'(cur_vals[i]);
            item_x[i*9 +: 9]   = 9'(cur_x[i]);
            item_y[i*9 +: 9]   = 9'(cur_y[i]);
        end
    endtask

    task automatic randomize_fields();
        for (int i = 0; i < N; i++) begin
            case ($urandom_range(0, 3))
                0:       cur_vals[i] = int'($urandom_range(0, 9));
                1:       cur_vals[i] = int'($urandom_range(0, 999));
                2:       cur_vals[i] = int'($urandom_range(0, 32767));
                default: cur_vals[i] = int'($urandom_range(10000, 32767));
            endcase
            cur_x[i] = int'($urandom_range(0, 511));
            cur_y[i] = int'($urandom_range(0, 511));
        end
        set_bus();
    endtask

    // Starts a draw on the main instance and records everything it emits
    task automatic run_draw(input int stall_pix, input int stall_len,
                            input int mid_cycle, input int abort_cycle);
        int stall_left = stall_len;
        int pix = 0;
        int post = -1;
        bit stall_seen = 1'b0;
        bit prev_busy = 1'b0;
        logic [8:0] sx = '0, sy = '0;
        logic [CW-1:0] sc = '0;
        logic [AW-1:0] sa = '0;
        cap_q.delete();
        done_cnt = 0; done_cyc = -1; stall_cycles = 0;
        busy_at_done = 1'b1; busy_pre_done = 1'b0; timed_out = 1'b0; stall_changed = 1'b0;
        post_busy = 1'b0; post_plot = 1'b0; aborted = 1'b0;
        @(negedge clock); go = 1'b1;
        @(negedge clock); go = 1'b0;
        busy_first = busy;
        for (int cyc = 0; cyc < 6000; cyc++) begin
            if (post >= 0) begin
                post_busy |= busy;
                post_plot |= plot;
                post++;
                if (post > 3) break;
            end
            if (plot && pix == stall_pix && stall_left > 0) begin
                plot_ready = 1'b0;
                if (stall_seen && (x !== sx || y !== sy || colour !== sc || rom_addr !== sa))
                    stall_changed = 1'b1;
                sx = x; sy = y; sc = colour; sa = rom_addr;
                stall_seen = 1'b1;
                stall_left--;
                stall_cycles++;
            end else begin
                plot_ready = 1'b1;
            end
            if (plot && plot_ready) begin
                cap_q.push_back('{int'(x), int'(y), int'(colour), int'(rom_addr)});
                pix++;
            end
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc = cyc; busy_at_done = busy; busy_pre_done = prev_busy; post = 0;
                end
            end
            if (cyc == mid_cycle) begin values = mid_values; go = 1'b1; end
            if (mid_cycle >= 0 && cyc == mid_cycle + 1) go = 1'b0;
            if (cyc == abort_cycle) begin
                busy_pre_abort = busy;
                resetn = 1'b0;
                @(negedge clock);
                abort_plot = plot; abort_busy = busy; abort_done = done;
                @(negedge clock);
                resetn = 1'b1;
                for (int k = 0; k < 4; k++) begin
                    @(negedge clock);
                    abort_done |= done;
                    abort_busy |= busy;
                end
                aborted = 1'b1;
                break;
            end
            prev_busy = busy;
            @(negedge clock);
        end
        if (done_cyc < 0 && !aborted) timed_out = 1'b1;
        plot_ready = 1'b1;
        go = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) @(negedge clock);
        n_tests++;
        if (plot !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: plot=%0b busy=%0b done=%0b, required all 0", plot, busy, done);
        end
        n_tests++;
        if (x !== 9'd0 || y !== 9'd0 || colour !== '0 || rom_addr !== '0) begin
            n_fail++;
            $display("FAIL reset_data: x=%0d y=%0d colour=%0d rom_addr=%0d, required all 0",
                     x, y, colour, rom_addr);
        end
        resetn = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_defaults();
        int first, m;
        cur_vals[0] = 0; cur_vals[1] = 7; cur_vals[2] = 305; cur_vals[3] = 32767; cur_vals[4] = 10000;
        for (int i = 0; i < N; i++) begin
            cur_x[i] = 40 + 90 * i;
            cur_y[i] = 20 + 40 * i;
        end
        set_bus();
        build_exp(cur_vals, cur_x, cur_y, N, ND);
        run_draw(-1, 0, -1, -1);
        n_tests++;
        if (timed_out) begin n_fail++; $display("FAIL defaults_timeout: no done within budget"); end
        n_tests++;
        if (cap_q.size() != 1350) begin
            n_fail++; $display("FAIL defaults_plots: got %0d plots, required 1350", cap_q.size());
        end
        n_tests++;
        if (done_cyc != DONE_CYC) begin
            n_fail++; $display("FAIL defaults_cycles: done at %0d, required %0d", done_cyc, DONE_CYC);
        end
        n_tests++;
        if (done_cnt != 1 || busy_at_done !== 1'b0 || busy_pre_done !== 1'b1 || busy_first !== 1'b1) begin
            n_fail++;
            $display("FAIL defaults_busy_done: dones=%0d busy@done=%0b busy_before=%0b busy_start=%0b, required 1/0/1/1",
                     done_cnt, busy_at_done, busy_pre_done, busy_first);
        end
        m = count_mism(first);
        n_tests++;
        if (m != 0) begin
            n_fail++;
            $display("FAIL defaults_pixels: %0d mismatches, first #%0d got x=%0d y=%0d c=%0d a=%0d required x=%0d y=%0d c=%0d a=%0d",
                     m, first, cap_q[first].x, cap_q[first].y, cap_q[first].c, cap_q[first].a,
                     exp_q[first].x, exp_q[first].y, exp_q[first].c, exp_q[first].a);
        end
    endtask

    task automatic test_blanking();
        int bad_blank = 0, bad_rom = 0, first, m;
        randomize_fields();
        cur_vals[0] = 305; cur_x[0] = 92; cur_y[0] = 36;
        set_bus();
        build_exp(cur_vals, cur_x, cur_y, N, ND);
        run_draw(-1, 0, -1, -1);
        n_tests++;
        if (cap_q.size() != 1350) begin
            n_fail++; $display("FAIL blank_plots: got %0d plots, required 1350", cap_q.size());
        end else begin
            n_tests++;
            if (cap_q[0].x != 92 || cap_q[0].y != 36 || cap_q[0].a != 30) begin
                n_fail++;
                $display("FAIL blank_first: got x=%0d y=%0d a=%0d, required x=92 y=36 a=30",
                         cap_q[0].x, cap_q[0].y, cap_q[0].a);
            end
            for (int i = 3 * 54; i < 5 * 54; i++)
                if (cap_q[i].c != 0 || cap_q[i].x < 68 || cap_q[i].x > 79) bad_blank++;
            for (int i = 0; i < 3 * 54; i++)
                if (cap_q[i].c != rom_fn(cap_q[i].a)) bad_rom++;
            n_tests++;
            if (bad_blank != 0) begin
                n_fail++; $display("FAIL blank_leading: %0d bad blanked pixels, required 0", bad_blank);
            end
            n_tests++;
            if (bad_rom != 0) begin
                n_fail++; $display("FAIL blank_rom: %0d low-digit pixels not from rom, required 0", bad_rom);
            end
        end
        m = count_mism(first);
        n_tests++;
        if (m != 0) begin
            n_fail++; $display("FAIL blank_pixels: %0d mismatches, first at #%0d, required 0", m, first);
        end
    endtask

    task automatic test_saturation();
        int vals3[8], xs3[8], ys3[8];
        int d3 = -1, not9 = 0, first, m;
        vals3[0] = 1234; vals3[1] = 999;
        for (int i = 0; i < 2; i++) begin
            xs3[i] = int'($urandom_range(0, 511));
            ys3[i] = int'($urandom_range(0, 511));
            values3[i*VW +: VW] = VW'(vals3[i]);
            item_x3[i*9 +: 9]   = 9'(xs3[i]);
            item_y3[i*9 +: 9]   = 9'(ys3[i]);
        end
        build_exp(vals3, xs3, ys3, 2, 3);
        cap_q.delete();
        @(negedge clock); go3 = 1'b1;
        @(negedge clock); go3 = 1'b0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            if (plot3) cap_q.push_back('{int'(x3), int'(y3), int'(colour3), int'(rom_addr3)});
            if (done3) begin d3 = cyc; break; end
            @(negedge clock);
        end
        n_tests++;
        if (d3 != 2 * PER_ITEM3 || cap_q.size() != 2 * 3 * 54) begin
            n_fail++;
            $display("FAIL sat_timing: done at %0d with %0d plots, required %0d and %0d",
                     d3, cap_q.size(), 2 * PER_ITEM3, 2 * 3 * 54);
        end else begin
            n_tests++;
            if (cap_q[0].a != 54) begin
                n_fail++; $display("FAIL sat_first_addr: got %0d, required 54", cap_q[0].a);
            end
            for (int i = 0; i < cap_q.size(); i++)
                if ((cap_q[i].a % 60) / 6 != 9) not9++;
            n_tests++;
            if (not9 != 0) begin
                n_fail++; $display("FAIL sat_glyphs: %0d pixels not glyph 9, required 0", not9);
            end
        end
        m = count_mism(first);
        n_tests++;
        if (m != 0) begin
            n_fail++; $display("FAIL sat_pixels: %0d mismatches, first at #%0d, required 0", m, first);
        end
    endtask

    task automatic test_stall();
        int first, m;
        randomize_fields();
        build_exp(cur_vals, cur_x, cur_y, N, ND);
        run_draw(9, 5, -1, -1);
        n_tests++;
        if (stall_cycles != 5 || stall_changed) begin
            n_fail++;
            $display("FAIL stall_hold: stalled %0d cycles changed=%0b, required 5 and 0", stall_cycles, stall_changed);
        end
        n_tests++;
        if (cap_q.size() != 1350 || done_cyc != DONE_CYC + 5) begin
            n_fail++;
            $display("FAIL stall_count: %0d plots done at %0d, required 1350 and %0d",
                     cap_q.size(), done_cyc, DONE_CYC + 5);
        end
        m = count_mism(first);
        n_tests++;
        if (m != 0) begin
            n_fail++; $display("FAIL stall_pixels: %0d mismatches, first at #%0d, required 0", m, first);
        end
    endtask

    task automatic test_snapshot();
        int first, m;
        randomize_fields();
        build_exp(cur_vals, cur_x, cur_y, N, ND);
        for (int i = 0; i < N; i++) mid_values[i*VW +: VW] = VW'((cur_vals[i] + 1111) % 32768);
        run_draw(-1, 0, 700, -1);
        n_tests++;
        if (done_cnt != 1 || done_cyc != DONE_CYC || cap_q.size() != 1350) begin
            n_fail++;
            $display("FAIL snap_go_ignored: dones=%0d at %0d plots=%0d, required 1 at %0d with 1350",
                     done_cnt, done_cyc, cap_q.size(), DONE_CYC);
        end
        m = count_mism(first);
        n_tests++;
        if (m != 0) begin
            n_fail++; $display("FAIL snap_pixels: %0d mismatches, first at #%0d, required 0", m, first);
        end
    endtask

    task automatic test_go_during_done();
        randomize_fields();
        build_exp(cur_vals, cur_x, cur_y, N, ND);
        for (int i = 0; i < N; i++) mid_values[i*VW +: VW] = VW'(int'($urandom_range(0, 32767)));
        run_draw(-1, 0, DONE_CYC, -1);
        n_tests++;
        if (done_cnt != 1 || post_busy || post_plot) begin
            n_fail++;
            $display("FAIL done_go_ignored: dones=%0d busy_after=%0b plot_after=%0b, required 1/0/0",
                     done_cnt, post_busy, post_plot);
        end
    endtask

    task automatic test_abort();
        int first, m;
        randomize_fields();
        run_draw(-1, 0, -1, 2 * PER_ITEM + 5);
        n_tests++;
        if (!aborted || busy_pre_abort !== 1'b1) begin
            n_fail++; $display("FAIL abort_reached: aborted=%0b busy_before=%0b, required 1/1", aborted, busy_pre_abort);
        end
        n_tests++;
        if (abort_plot !== 1'b0 || abort_busy !== 1'b0 || abort_done !== 1'b0 || cap_q.size() != 2 * 270) begin
            n_fail++;
            $display("FAIL abort_state: plot=%0b busy=%0b done=%0b plots=%0d, required 0/0/0/540",
                     abort_plot, abort_busy, abort_done, cap_q.size());
        end
        randomize_fields();
        build_exp(cur_vals, cur_x, cur_y, N, ND);
        run_draw(-1, 0, -1, -1);
        m = count_mism(first);
        n_tests++;
        if (m != 0 || cap_q.size() != 1350 || done_cyc != DONE_CYC) begin
            n_fail++;
            $display("FAIL abort_redraw: %0d mismatches plots=%0d done at %0d, required 0/1350/%0d",
                     m, cap_q.size(), done_cyc, DONE_CYC);
        end
    endtask

    task automatic test_random();
        int first, m;
        for (int r = 0; r < 3; r++) begin
            randomize_fields();
            build_exp(cur_vals, cur_x, cur_y, N, ND);
            run_draw(-1, 0, -1, -1);
            m = count_mism(first);
            n_tests++;
            if (m != 0 || cap_q.size() != exp_q.size() || done_cyc != DONE_CYC) begin
                n_fail++;
                $display("FAIL random_%0d: %0d mismatches (first #%0d) plots=%0d done at %0d, required 0/%0d/%0d",
                         r, m, first, cap_q.size(), done_cyc, exp_q.size(), DONE_CYC);
            end
        end
    endtask

    task automatic test_back_to_back();
        int first, m;
        for (int r = 0; r < 2; r++) begin
            randomize_fields();
            build_exp(cur_vals, cur_x, cur_y, N, ND);
            run_draw(-1, 0, -1, -1);
            m = count_mism(first);
            n_tests++;
            if (m != 0 || cap_q.size() != 1350 || done_cnt != 1) begin
                n_fail++;
                $display("FAIL b2b_%0d: %0d mismatches plots=%0d dones=%0d, required 0/1350/1",
                         r, m, cap_q.size(), done_cnt);
            end
        end
    endtask

    initial begin
        test_reset();
        test_defaults();
        test_blanking();
        test_saturation();
        test_stall();
        test_snapshot();
        test_go_during_done();
        test_abort();
        test_random();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
